// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
// data_memory_lsu : byte-addressed word RAM with lane stores, extended loads,
//   valid/ready requests and an RD_LAT-deep in-order response pipeline.
//   Optional macro DMEM_INIT_CLEAR_EN adds a zero-fill sweep after reset.
// Rev 1.0
// ============================================================================
module data_memory_lsu #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 16,
  parameter  int RD_LAT = 1,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic                    sysCLK,
  input  logic                    sysRST,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [1:0]              reqSize,
  input  logic                    reqUnsigned,
  input  logic [ADDR_W+OFF_W-1:0] reqAddr,
  input  logic [DATA_W-1:0]       reqWData,
  output logic                    rspValid,
  output logic [DATA_W-1:0]       rspData,
  output logic                    rspErr
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAST  = RD_LAT - 1;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd2;
`ifdef DMEM_INIT_CLEAR_EN
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_FIRST = ST_INIT;
`else
  localparam logic [1:0] ST_FIRST = ST_RUN;
`endif

  logic [1:0]        state_q, state_d, cur_state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] req_word;
  logic [2:0]        size_m1;
  logic              req_err;
  logic [LANES-1:0]  wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

`ifdef DMEM_INIT_CLEAR_EN
  logic              init_we;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
`endif

  // Reset is folded into the decoded state so that RST is visible the
  // moment sysRST rises, and the register already holds the successor.
  assign cur_state = sysRST ? ST_RST : state_q;

  always_ff @(posedge sysCLK) begin
    if (sysRST) state_q <= ST_FIRST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = cur_state;
    case (cur_state)
      ST_RST:  state_d = ST_FIRST;
`ifdef DMEM_INIT_CLEAR_EN
      ST_INIT: if (init_cnt_q == '1) state_d = ST_RUN;
`endif
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_FIRST;
    endcase
  end

  always_comb begin
    reqReady = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
    init_we  = 1'b0;
`endif
    case (cur_state)
      ST_RUN:  reqReady = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
      ST_INIT: init_we  = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef DMEM_INIT_CLEAR_EN
  always_comb init_cnt_d = (cur_state == ST_INIT) ? init_cnt_q + 1'b1 : '0;

  always_ff @(posedge sysCLK) begin
    if (sysRST) init_cnt_q <= '0;
    else        init_cnt_q <= init_cnt_d;
  end
`endif

  assign accept   = reqValid & reqReady;
  assign req_off  = reqAddr[OFF_W-1:0];
  assign req_word = reqAddr[ADDR_W+OFF_W-1:OFF_W];

  always_comb begin
    size_m1 = 3'((4'd1 << reqSize) - 4'd1);
    req_err = (int'(reqSize) > OFF_W) | (|(3'(req_off) & size_m1));
  end

  always_comb begin
    wr_en   = '0;
    wr_addr = req_word;
    wr_data = reqWData << {req_off, 3'b000};
`ifdef DMEM_INIT_CLEAR_EN
    if (init_we) begin
      wr_en   = '1;
      wr_addr = init_cnt_q;
      wr_data = '0;
    end else
`endif
    if (accept && reqWrite && !req_err) begin
      for (int i = 0; i < LANES; i++) begin
        wr_en[i] = (i >= int'(req_off)) && (i < int'(req_off) + (1 << reqSize));
      end
    end
  end

  always_ff @(posedge sysCLK) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Response pipeline: stage 0 captures the raw word at the accept edge,
  // formatting happens only on the output stage.
  logic [RD_LAT-1:0] vld_q, vld_d, err_q, err_d, ld_q, ld_d, uns_q, uns_d;
  logic [1:0]        size_q [RD_LAT];
  logic [1:0]        size_d [RD_LAT];
  logic [OFF_W-1:0]  off_q  [RD_LAT];
  logic [OFF_W-1:0]  off_d  [RD_LAT];
  logic [DATA_W-1:0] word_q [RD_LAT];
  logic [DATA_W-1:0] word_d [RD_LAT];

  always_comb begin
    vld_d  = vld_q;
    err_d  = err_q;
    ld_d   = ld_q;
    uns_d  = uns_q;
    size_d = size_q;
    off_d  = off_q;
    word_d = word_q;
    vld_d[0]  = accept;
    err_d[0]  = req_err;
    ld_d[0]   = ~reqWrite;
    uns_d[0]  = reqUnsigned;
    size_d[0] = reqSize;
    off_d[0]  = req_off;
    word_d[0] = mem[req_word];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      err_d[i]  = err_q[i-1];
      ld_d[i]   = ld_q[i-1];
      uns_d[i]  = uns_q[i-1];
      size_d[i] = size_q[i-1];
      off_d[i]  = off_q[i-1];
      word_d[i] = word_q[i-1];
    end
  end

  always_ff @(posedge sysCLK) begin
    if (sysRST) vld_q <= '0;
    else        vld_q <= vld_d;
    err_q  <= err_d;
    ld_q   <= ld_d;
    uns_q  <= uns_d;
    size_q <= size_d;
    off_q  <= off_d;
    word_q <= word_d;
  end

  logic [DATA_W-1:0] shifted, mask, extended;
  logic              sign_bit, rsp_live;

  always_comb begin
    shifted = word_q[LAST] >> {off_q[LAST], 3'b000};
    case (size_q[LAST])
      2'd0:    mask = DATA_W'(8'hFF);
      2'd1:    mask = DATA_W'(16'hFFFF);
      2'd2:    mask = DATA_W'(32'hFFFF_FFFF);
      default: mask = '1;
    endcase
    sign_bit = ~uns_q[LAST] & (|(shifted & mask & ~(mask >> 1)));
    extended = (shifted & mask) | ({DATA_W{sign_bit}} & ~mask);
    rsp_live = vld_q[LAST] & ~sysRST;
    rspValid = rsp_live;
    rspErr   = rsp_live & err_q[LAST];
    rspData  = (rsp_live & ld_q[LAST] & ~err_q[LAST]) ? extended : '0;
  end

endmodule
`default_nettype wire
